multi_cam_cfg_seq: RTL and testbench

MULTI_CAM_CFG_SEQ -- requirements
Module: multi_cam_cfg_seq

---
 rtl/multi_cam_cfg_seq.sv | 179 +++++++++++++++++
 tb/tb_multi_cam_cfg_seq.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cam_cfg_seq.sv
// Power-up and I2C configuration sequencer for up to eight camera sensors.
// Define CAM_CFG_RETRY_EN to retry a failed camera up to MAX_RETRY extra times.
module multi_cam_cfg_seq #(
    parameter int unsigned NUM_CAMS  = 3,
    parameter logic [23:0] SEL_MAP   = 24'o76543101,
    parameter logic [2:0]  SEL_IDLE  = 3'b000,
    parameter int unsigned RST_DLY   = 100000,
    parameter int unsigned CFG_DLY   = 3000000,
    parameter int unsigned SETTLE    = 16,
    parameter int unsigned TIMEOUT   = 2000000,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CAMS-1:0] cam_en,
    input  logic                start,
    input  logic                cfg_done,
    input  logic                cfg_err,
    output logic                cfg_rst,
    output logic [2:0]          i2c_sel,
    output logic [NUM_CAMS-1:0] cam_reset_n,
    output logic [NUM_CAMS-1:0] cam_ok,
    output logic [NUM_CAMS-1:0] cam_fail,
    output logic                busy,
    output logic                all_done
);

    localparam int unsigned IdxW = (NUM_CAMS > 1) ? $clog2(NUM_CAMS) : 1;

    if (CFG_DLY <= RST_DLY || NUM_CAMS < 1 || NUM_CAMS > 8 || MAX_RETRY > 255)
    begin : g_param_check
        $error("multi_cam_cfg_seq: illegal parameter combination");
    end

    typedef enum logic [2:0] {StPwrUp, StSelect, StSettle, StRun, StNext, StDone} state_e;

    state_e              state_q, state_d;
    logic [31:0]         cnt_q, cnt_d, cnt_inc;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic                cam_rel_q, cam_rel_d;
    logic [NUM_CAMS-1:0] ok_q, ok_d, fail_q, fail_d;
    logic [NUM_CAMS-1:0] idx_oh;
    logic [2:0]          sel_cam;
    logic                cam_sel_en;

`ifdef CAM_CFG_RETRY_EN
    localparam int unsigned AttW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [AttW-1:0] att_q, att_d;
`endif

    // Decode the current camera index into its one-hot flag, mux code and enable.
    always_comb begin
        idx_oh     = '0;
        sel_cam    = SEL_IDLE;
        cam_sel_en = 1'b0;
        for (int k = 0; k < NUM_CAMS; k++) begin
            if (idx_q == IdxW'(k)) begin
                idx_oh[k]  = 1'b1;
                sel_cam    = SEL_MAP[3*k +: 3];
                cam_sel_en = cam_en[k];
            end
        end
    end

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        cam_rel_d = cam_rel_q;
        ok_d      = ok_q;
        fail_d    = fail_q;
`ifdef CAM_CFG_RETRY_EN
        att_d     = att_q;
`endif
        case (state_q)
            StPwrUp: begin
                cnt_d = cnt_inc;
                if (cnt_inc >= RST_DLY) cam_rel_d = 1'b1;
                if (cnt_inc == CFG_DLY) begin
                    cnt_d   = '0;
                    state_d = StSelect;
                end
            end
            StSelect: begin
                if (cam_sel_en) begin
`ifdef CAM_CFG_RETRY_EN
                    att_d = '0;
`endif
                    cnt_d   = '0;
                    state_d = StSettle;
                end else begin
                    state_d = StNext;
                end
            end
            StSettle: begin
                cnt_d = cnt_inc;
                if (cnt_inc >= SETTLE) begin
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                cnt_d = cnt_inc;
                if (cfg_done) begin
                    ok_d    = ok_q | idx_oh;
                    state_d = StNext;
                end else if (cfg_err || cnt_inc >= TIMEOUT) begin
`ifdef CAM_CFG_RETRY_EN
                    if (att_q < AttW'(MAX_RETRY)) begin
                        att_d   = att_q + AttW'(1);
                        cnt_d   = '0;
                        state_d = StSettle;
                    end else begin
                        fail_d  = fail_q | idx_oh;
                        state_d = StNext;
                    end
`else
                    fail_d  = fail_q | idx_oh;
                    state_d = StNext;
`endif
                end
            end
            StNext: begin
                if (idx_q == IdxW'(NUM_CAMS - 1)) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + IdxW'(1);
                    state_d = StSelect;
                end
            end
            StDone: begin
                // Restart skips power-up: sensors are already out of reset.
                if (start) begin
                    ok_d    = '0;
                    fail_d  = '0;
                    idx_d   = '0;
                    state_d = StSelect;
                end
            end
            default: state_d = StPwrUp;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StPwrUp;
            cnt_q     <= '0;
            idx_q     <= '0;
            cam_rel_q <= 1'b0;
            ok_q      <= '0;
            fail_q    <= '0;
`ifdef CAM_CFG_RETRY_EN
            att_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            cam_rel_q <= cam_rel_d;
            ok_q      <= ok_d;
            fail_q    <= fail_d;
`ifdef CAM_CFG_RETRY_EN
            att_q     <= att_d;
`endif
        end
    end

    assign cfg_rst     = (state_q != StRun);
    assign i2c_sel     = (state_q == StSettle || state_q == StRun) ? sel_cam : SEL_IDLE;
    assign busy        = (state_q == StSelect || state_q == StSettle ||
                          state_q == StRun    || state_q == StNext);
    assign all_done    = (state_q == StDone);
    assign cam_reset_n = {NUM_CAMS{cam_rel_q}};
    assign cam_ok      = ok_q;
    assign cam_fail    = fail_q;

endmodule

// File: tb/tb_multi_cam_cfg_seq.sv
// Scoreboard bench for multi_cam_cfg_seq: a task-level model predicts every RUN attempt
// (mux code, length) and the final flags; an engine emulator answers each RUN.
module tb_multi_cam_cfg_seq;

    localparam int unsigned NC   = 3;
    localparam logic [23:0] MAP  = 24'o76543651;
    localparam logic [2:0]  IDLE = 3'b000;
    localparam int unsigned RDLY = 10;
    localparam int unsigned CDLY = 40;
    localparam int unsigned STL  = 4;
    localparam int unsigned TMO  = 50;
    localparam int unsigned MR   = 2;
`ifdef CAM_CFG_RETRY_EN
    localparam int ATTEMPTS = MR + 1;
`else
    localparam int ATTEMPTS = 1;
`endif
    localparam int KDone = 0, KErr = 1, KBoth = 2, KNone = 3;

    typedef struct {logic [2:0] sel; int len;} run_t;
    typedef struct {int kind; int dly;} resp_t;
    typedef struct {logic [2:0] ok; logic [2:0] fail;} fin_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NC-1:0] cam_en;
    logic          start;
    logic          cfg_done, cfg_err;
    logic          cfg_rst;
    logic [2:0]    i2c_sel;
    logic [NC-1:0] cam_reset_n, cam_ok, cam_fail;
    logic          busy, all_done;

    run_t  exp_runs[$];
    resp_t exp_resp[$];
    fin_t  exp_fin[$];
    int    chk = 0;
    int    errs = 0;

    always #5 clk = ~clk;

    multi_cam_cfg_seq #(
        .NUM_CAMS (NC),
        .SEL_MAP  (MAP),
        .SEL_IDLE (IDLE),
        .RST_DLY  (RDLY),
        .CFG_DLY  (CDLY),
        .SETTLE   (STL),
        .TIMEOUT  (TMO),
        .MAX_RETRY(MR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cam_en     (cam_en),
        .start      (start),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .cfg_rst    (cfg_rst),
        .i2c_sel    (i2c_sel),
        .cam_reset_n(cam_reset_n),
        .cam_ok     (cam_ok),
        .cam_fail   (cam_fail),
        .busy       (busy),
        .all_done   (all_done)
    );

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [2:0] sel_of(input int k);
        logic [23:0] m;
        m = MAP;
        return m[3*k +: 3];
    endfunction

    // Reference model: each enabled camera gets up to ATTEMPTS runs; a run lasts until the
    // engine answers or TMO cycles pass, and cfg_done wins over cfg_err.
    task automatic plan(input logic [2:0] en, input int k0, input int k1, input int k2,
                        input int dly, input bit rnd);
        int    kinds[3];
        resp_t r;
        run_t  a;
        fin_t  f;
        kinds  = '{k0, k1, k2};
        f.ok   = '0;
        f.fail = '0;
        for (int k = 0; k < NC; k++) begin
            if (en[k]) begin
                for (int t = 0; t < ATTEMPTS; t++) begin
                    r.kind = rnd ? int'($urandom_range(0, 3)) : kinds[k];
                    r.dly  = rnd ? int'($urandom_range(1, 60)) : dly;
                    exp_resp.push_back(r);
                    a.sel = sel_of(k);
                    a.len = (r.kind == KNone || r.dly > int'(TMO)) ? int'(TMO) : r.dly;
                    exp_runs.push_back(a);
                    if ((r.kind == KDone || r.kind == KBoth) && r.dly <= int'(TMO)) begin
                        f.ok[k] = 1'b1;
                        break;
                    end
                    if (t == ATTEMPTS - 1) f.fail[k] = 1'b1;
                end
            end
        end
        exp_fin.push_back(f);
    endtask

    // I2C engine emulator: answers each RUN per the next planned response.
    resp_t r_cur;
    bit    r_act;
    int    r_n;
    always @(negedge clk) begin
        if (!rst_n || cfg_rst) begin
            cfg_done = 1'b0;
            cfg_err  = 1'b0;
            r_act    = 1'b0;
            r_n      = 0;
        end else begin
            if (!r_act) begin
                r_act = 1'b1;
                r_n   = 0;
                if (exp_resp.size() > 0) r_cur = exp_resp.pop_front();
                else begin
                    r_cur.kind = KNone;
                    r_cur.dly  = 0;
                end
            end
            r_n++;
            if (r_n == r_cur.dly && r_cur.kind != KNone) begin
                cfg_done = (r_cur.kind == KDone || r_cur.kind == KBoth);
                cfg_err  = (r_cur.kind == KErr  || r_cur.kind == KBoth);
            end
        end
    end

    // Monitor: checks each RUN (mux code, settle length, run length) and each completion.
    bit   prev_rst, prev_done, in_run;
    int   run_len, stl_n;
    run_t cur;
    fin_t fin;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rst  = 1'b1;
            prev_done = 1'b0;
            in_run    = 1'b0;
            stl_n     = 0;
        end else begin
            if (!busy) begin
                check("idle_cfg_rst", cfg_rst, 1);
                check("idle_i2c_sel", i2c_sel, IDLE);
            end
            if (prev_rst && !cfg_rst) begin
                check("settle_len", stl_n, STL);
                stl_n = 0;
                if (exp_runs.size() == 0) begin
                    chk++;
                    errs++;
                    $display("FAIL unexpected_run: got sel %0h, expected no run", i2c_sel);
                    in_run = 1'b0;
                end else begin
                    cur = exp_runs.pop_front();
                    check("run_i2c_sel", i2c_sel, cur.sel);
                    in_run  = 1'b1;
                    run_len = 1;
                end
            end else if (in_run && !cfg_rst) begin
                run_len++;
            end else if (in_run && cfg_rst) begin
                check("run_len", run_len, cur.len);
                in_run = 1'b0;
            end
            if (cfg_rst && i2c_sel != IDLE) stl_n++;
            else if (i2c_sel == IDLE) stl_n = 0;
            if (!prev_done && all_done) begin
                if (exp_fin.size() == 0) begin
                    chk++;
                    errs++;
                    $display("FAIL unexpected_done: got ok %0h, expected none", cam_ok);
                end else begin
                    fin = exp_fin.pop_front();
                    check("final_cam_ok", cam_ok, fin.ok);
                    check("final_cam_fail", cam_fail, fin.fail);
                end
            end
            prev_rst  = cfg_rst;
            prev_done = all_done;
        end
    end

    task automatic flush();
        exp_runs.delete();
        exp_resp.delete();
        exp_fin.delete();
    endtask

    task automatic wait_done();
        int n = 0;
        while (!all_done && n < 2500) begin
            @(negedge clk);
            n++;
        end
        check("done_in_time", all_done, 1);
        @(negedge clk);
        check("runs_consumed", exp_runs.size(), 0);
        check("fin_consumed", exp_fin.size(), 0);
        flush();
    endtask

    task automatic power_up_run();
        int cyc = 0, rise = -1, fall = -1;
        @(negedge clk);
        rst_n = 1'b1;
        while ((rise < 0 || fall < 0) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (rise < 0 && cam_reset_n != '0) begin
                rise = cyc;
                check("cam_reset_n_high", cam_reset_n, 3'b111);
            end
            if (fall < 0 && !cfg_rst) fall = cyc;
        end
        check("cam_reset_rise_cycle", rise, RDLY);
        check("first_run_cycle", fall, CDLY + 1 + STL);
        wait_done();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic kick(input logic [2:0] en);
        cam_en = en;
        pulse_start();
        check("start_clears_done", all_done, 0);
        check("start_clears_ok", cam_ok, 0);
        check("start_clears_fail", cam_fail, 0);
        check("start_busy", busy, 1);
        check("start_keeps_cam_reset", cam_reset_n, 3'b111);
    endtask

    initial begin
        int          falls, n;
        bit          prev;
        logic [2:0]  en;
        rst_n  = 1'b0;
        start  = 1'b0;
        cam_en = 3'b111;
        repeat (3) @(negedge clk);
        check("rst_cfg_rst", cfg_rst, 1);
        check("rst_i2c_sel", i2c_sel, IDLE);
        check("rst_cam_reset_n", cam_reset_n, 0);
        check("rst_cam_ok", cam_ok, 0);
        check("rst_cam_fail", cam_fail, 0);
        check("rst_busy", busy, 0);
        check("rst_all_done", all_done, 0);

        plan(3'b111, KDone, KDone, KDone, 20, 1'b0);
        power_up_run();
        check("done_busy_low", busy, 0);

        plan(3'b101, KDone, KDone, KDone, 20, 1'b0);
        kick(3'b101);
        wait_done();

        plan(3'b111, KDone, KDone, KErr, 20, 1'b0);
        kick(3'b111);
        wait_done();

        plan(3'b111, KNone, KNone, KNone, 0, 1'b0);
        kick(3'b111);
        wait_done();

        plan(3'b111, KBoth, KBoth, KBoth, 15, 1'b0);
        kick(3'b111);
        wait_done();

        for (int s = 0; s < 8; s++) begin
            en = (s == 0) ? 3'b111 : 3'($urandom_range(0, 7));
            plan(en, 0, 0, 0, 0, 1'b1);
            kick(en);
            if (s == 0) begin
                repeat (30) @(negedge clk);
                pulse_start();
            end
            wait_done();
        end

        // Reset in the middle of the second camera's RUN.
        plan(3'b111, KDone, KDone, KDone, 20, 1'b0);
        kick(3'b111);
        falls = 0;
        n     = 0;
        prev  = 1'b1;
        while (falls < 2 && n < 2000) begin
            @(negedge clk);
            n++;
            if (prev && !cfg_rst) falls++;
            prev = cfg_rst;
        end
        check("reached_second_run", falls, 2);
        check("ok_before_reset", cam_ok, 3'b001);
        #3 rst_n = 1'b0;
        #1;
        check("async_cfg_rst", cfg_rst, 1);
        check("async_i2c_sel", i2c_sel, IDLE);
        check("async_cam_reset_n", cam_reset_n, 0);
        check("async_cam_ok", cam_ok, 0);
        check("async_cam_fail", cam_fail, 0);
        check("async_busy", busy, 0);
        check("async_all_done", all_done, 0);
        flush();
        repeat (2) @(negedge clk);
        plan(3'b111, KDone, KDone, KDone, 20, 1'b0);
        power_up_run();

        $display("Simulation finished: %0d checks, %0d errors", chk, errs);
        $finish;
    end

endmodule
